// File: rtl/fabric_simple_initiator_pkg.sv
// Shared types and constants for the simple fabric initiator:
// the FSM state encoding and the transaction-counter width.
package fabric_simple_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } fabric_init_state_t;

  localparam int TXN_CNT_W = 16;

  // Saturating increment so the counter sticks at all-ones.
  function automatic logic [TXN_CNT_W-1:0] sat_inc(input logic [TXN_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fabric_simple_initiator_if.sv
// User command/response and fabric request/response signals of the initiator.
// The master modport is the initiator's view; slave is the surrounding environment.
interface fabric_simple_initiator_if #(
  parameter int WIDTH = 32
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [WIDTH-1:0] cmd_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;
  logic             req_valid;
  logic             read_req;
  logic             write_req;
  logic [WIDTH-1:0] write_data;
  logic             resp_valid;
  logic [WIDTH-1:0] read_data;

  modport master (
    input  cmd_valid, cmd_write, cmd_wdata, rsp_ready, resp_valid, read_data,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           req_valid, read_req, write_req, write_data
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_wdata, rsp_ready, resp_valid, read_data,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           req_valid, read_req, write_req, write_data
  );

endinterface

// File: rtl/fabric_simple_initiator_timer.sv
// WAIT-state timeout counter; only present when FABRIC_INIT_TIMEOUT_EN is defined.
// Counts cycles while active and flags the last permitted WAIT cycle.
`ifdef FABRIC_INIT_TIMEOUT_EN
module fabric_init_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic expired
);

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  // NOTE: the counter is held at zero whenever WAIT is not active, so entry
  // into WAIT always starts from zero without a separate clear strobe.
  always_ff @(posedge clk) begin
    if (rst || !active) begin
      count <= '0;
    end else if (count != 16'hFFFF) begin
      count <= count + 16'd1;
    end
  end

  assign expired = active && (count == LAST_CNT);

endmodule
`endif

// File: rtl/fabric_simple_initiator.sv
// Single-outstanding fabric initiator: user command -> fabric request -> user response.
// Define FABRIC_INIT_TIMEOUT_EN to add a WAIT-state timeout that returns rsp_err=1.
module fabric_simple_initiator
  import fabric_simple_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  fabric_simple_initiator_if.master   bus,
  output logic                        stray_resp,
  output logic [TXN_CNT_W-1:0]        txn_count
);

  fabric_init_state_t state;
  logic               is_write;
  logic               timeout_hit;

  assign bus.cmd_ready = (state == IDLE);

`ifdef FABRIC_INIT_TIMEOUT_EN
  fabric_init_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .active  (state == WAIT),
    .expired (timeout_hit)
  );
`else
  // No timeout hardware; the parameter only matters when the timer exists.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // update in this block sees the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      is_write       <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.rsp_err    <= 1'b0;
      bus.req_valid  <= 1'b0;
      bus.read_req   <= 1'b0;
      bus.write_req  <= 1'b0;
      bus.write_data <= '0;
      stray_resp     <= 1'b0;
      txn_count      <= '0;
    end else begin
      // Any fabric response outside WAIT is unsolicited and only flagged.
      if (bus.resp_valid && (state != WAIT)) begin
        stray_resp <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            is_write       <= bus.cmd_write;
            bus.req_valid  <= 1'b1;
            bus.write_req  <= bus.cmd_write;
            bus.read_req   <= !bus.cmd_write;
            bus.write_data <= bus.cmd_wdata;
            state          <= REQ;
          end
        end

        REQ: begin
          bus.req_valid  <= 1'b0;
          bus.write_req  <= 1'b0;
          bus.read_req   <= 1'b0;
          bus.write_data <= '0;
          state          <= WAIT;
        end

        WAIT: begin
          // A response arriving on the expiry cycle takes precedence.
          if (bus.resp_valid) begin
            bus.rsp_rdata <= is_write ? {WIDTH{1'b0}} : bus.read_data;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else if (timeout_hit) begin
            bus.rsp_rdata <= {WIDTH{1'b0}};
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            txn_count     <= sat_inc(txn_count);
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fabric_simple_initiator.sv
// Directed bench for fabric_simple_initiator: expected requests/responses are
// queued at issue time and checked by independent monitors on the falling edge.
module tb_fabric_simple_initiator;
  import fabric_simple_pkg::*;

  localparam int WIDTH      = 32;
  localparam int TB_TIMEOUT = 4;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] rdata;
  } rsp_t;

  typedef struct packed {
    logic             write;
    logic [WIDTH-1:0] data;
  } req_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 stray_resp;
  logic [TXN_CNT_W-1:0] txn_count;

  fabric_simple_initiator_if #(.WIDTH(WIDTH)) bus ();

  fabric_simple_initiator #(
    .WIDTH          (WIDTH),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .stray_resp (stray_resp),
    .txn_count  (txn_count)
  );

  always #5 clk = ~clk;

  rsp_t sb_q[$];
  req_t req_q[$];
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   req_pulses  = 0;
  int   outstanding = 0;
  logic prev_req    = 1'b0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fabric-side monitor: request pulses and their contents.
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (bus.req_valid) begin
        req_t exp_req;
        req_pulses++;
        check("req_single_cycle", WIDTH'(prev_req), '0);
        check("one_outstanding", WIDTH'(outstanding), '0);
        outstanding = 1;
        if (req_q.size() == 0) begin
          check("unexpected_req", 32'd1, 32'd0);
        end else begin
          exp_req = req_q.pop_front();
          check("write_req", WIDTH'(bus.write_req), WIDTH'(exp_req.write));
          check("read_req", WIDTH'(bus.read_req), WIDTH'(!exp_req.write));
          check("write_data", bus.write_data, exp_req.data);
        end
      end
      prev_req = bus.req_valid;
    end
  end

  // User-side monitor: every presented response must be expected; pop on handshake.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else if (bus.rsp_ready) begin
        rsp_t exp_rsp;
        exp_rsp = sb_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, exp_rsp.rdata);
        check("rsp_err", WIDTH'(bus.rsp_err), WIDTH'(exp_rsp.err));
        outstanding = 0;
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
    req_q.delete();
    outstanding = 0;
  endtask

  task automatic send_cmd(input logic w, input logic [WIDTH-1:0] d, input rsp_t exp_rsp);
    bit ok = 1'b0;
    req_q.push_back('{write: w, data: d});
    sb_q.push_back(exp_rsp);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_wdata = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    if (!ok) check("cmd_accept_timeout", 32'd1, 32'd0);
  endtask

  // Waits for a request pulse, then drives resp_valid 'delay' cycles later.
  task automatic fabric_respond(input int delay, input logic [WIDTH-1:0] data);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("req_wait_timeout", 32'd1, 32'd0);
    repeat (delay) @(posedge clk);
    #1;
    bus.resp_valid = 1'b1;
    bus.read_data  = data;
    @(posedge clk);
    #1;
    bus.resp_valid = 1'b0;
    bus.read_data  = '0;
  endtask

  task automatic wait_drained();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, WIDTH'(bus.cmd_ready), 32'd1);
    check({tag, "_rsp_valid"}, WIDTH'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, WIDTH'(bus.rsp_err), 32'd0);
    check({tag, "_req_valid"}, WIDTH'(bus.req_valid), 32'd0);
    check({tag, "_read_req"}, WIDTH'(bus.read_req), 32'd0);
    check({tag, "_write_req"}, WIDTH'(bus.write_req), 32'd0);
    check({tag, "_write_data"}, bus.write_data, 32'd0);
    check({tag, "_stray_resp"}, WIDTH'(stray_resp), 32'd0);
    check({tag, "_txn_count"}, WIDTH'(txn_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] b2b_data [3];
    int               base_pulses;
    int               accepted;
    bit               seen;

    b2b_data[0] = 32'h1111_0001;
    b2b_data[1] = 32'h2222_0002;
    b2b_data[2] = 32'h3333_0003;

    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.read_data  = '0;

    apply_reset();
    check_reset_values("reset");

    // Write DEADBEEF, fabric answers two cycles after the request.
    bus.rsp_ready = 1'b1;
    send_cmd(1'b1, 32'hDEAD_BEEF, '{err: 1'b0, rdata: 32'h0});
    fabric_respond(2, 32'hFFFF_FFFF);
    wait_drained();
    check("write_txn_count", WIDTH'(txn_count), 32'd1);

    // Read held for five cycles with rsp_ready low.
    bus.rsp_ready = 1'b0;
    send_cmd(1'b0, 32'h0000_00A5, '{err: 1'b0, rdata: 32'h1234_5678});
    fabric_respond(2, 32'h1234_5678);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("hold_rsp_seen", WIDTH'(seen), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("hold_rsp_valid", WIDTH'(bus.rsp_valid), 32'd1);
      check("hold_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    wait_drained();
    check("read_txn_count", WIDTH'(txn_count), 32'd2);

    // Unsolicited fabric response while IDLE.
    check("stray_before", WIDTH'(stray_resp), 32'd0);
    @(posedge clk);
    #1;
    bus.resp_valid = 1'b1;
    bus.read_data  = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    bus.resp_valid = 1'b0;
    bus.read_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("stray_idle_flag", WIDTH'(stray_resp), 32'd1);
    check("stray_idle_no_rsp", WIDTH'(bus.rsp_valid), 32'd0);
    check("stray_idle_txn_count", WIDTH'(txn_count), 32'd2);

    // Minimum latency: resp_valid one cycle after the request.
    send_cmd(1'b0, 32'h0, '{err: 1'b0, rdata: 32'h0BAD_F00D});
    fabric_respond(1, 32'h0BAD_F00D);
    check("min_latency_rsp_valid", WIDTH'(bus.rsp_valid), 32'd1);
    wait_drained();
    check("min_latency_txn_count", WIDTH'(txn_count), 32'd3);

    // Reset during WAIT; fabric responds while reset is still asserted.
    send_cmd(1'b0, 32'h0, '{err: 1'b0, rdata: 32'hCAFE_0000});
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_wait_req_seen", WIDTH'(seen), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_valid = 1'b1;
    bus.read_data  = 32'hCAFE_0000;
    @(posedge clk);
    #1;
    bus.resp_valid = 1'b0;
    bus.read_data  = '0;
    rst            = 1'b0;
    sb_q.delete();
    req_q.delete();
    outstanding = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("mid_rst");

    // Three back-to-back reads with cmd_valid held high.
    base_pulses = req_pulses;
    fork
      begin
        for (int k = 0; k < 3; k++) fabric_respond(1, b2b_data[k]);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          req_q.push_back('{write: 1'b0, data: 32'h0000_0055});
          sb_q.push_back('{err: 1'b0, rdata: b2b_data[k]});
        end
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = 32'h0000_0055;
        bus.cmd_valid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 100 && accepted < 3; i++) begin
          @(negedge clk);
          if (bus.cmd_ready) accepted++;
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        check("b2b_accepted", WIDTH'(accepted), 32'd3);
      end
    join
    wait_drained();
    repeat (3) @(posedge clk);
    #1;
    check("b2b_req_pulses", WIDTH'(req_pulses - base_pulses), 32'd3);
    check("b2b_txn_count", WIDTH'(txn_count), 32'd3);

`ifdef FABRIC_INIT_TIMEOUT_EN
    // Silent fabric: error response after TB_TIMEOUT WAIT cycles, late response is stray.
    apply_reset();
    bus.rsp_ready = 1'b1;
    send_cmd(1'b0, 32'h0, '{err: 1'b1, rdata: 32'h0});
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("timeout_req_seen", WIDTH'(seen), 32'd1);
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      accepted++;
      if (bus.rsp_valid) break;
    end
    check("timeout_latency", WIDTH'(accepted), WIDTH'(TB_TIMEOUT + 1));
    check("timeout_stray_before", WIDTH'(stray_resp), 32'd0);
    @(posedge clk);
    #1;
    bus.resp_valid = 1'b1;
    bus.read_data  = 32'h7777_7777;
    @(posedge clk);
    #1;
    bus.resp_valid = 1'b0;
    bus.read_data  = '0;
    @(posedge clk);
    #1;
    check("timeout_late_stray", WIDTH'(stray_resp), 32'd1);
    check("timeout_txn_count", WIDTH'(txn_count), 32'd1);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("final_queues_empty", WIDTH'(sb_q.size() + req_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
